// File: rtl/hls_kernel_shell.sv
// Host-side shell around one HLS kernel: burst-reads a job into a local buffer,
// starts the kernel on it, then writes the buffer back and reports done/error.
module hls_kernel_shell #(
  parameter int DATA_WID    = 32,
  parameter int ADDR_WID    = 5,
  parameter int CNT_WID     = 16,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic [63:0]         read_stride,
  input  logic [63:0]         write_stride,
  input  logic [CNT_WID-1:0]  num_read,
  input  logic [CNT_WID-1:0]  num_write,
  input  logic                read_ready,
  input  logic [DATA_WID-1:0] read_data,
  output logic                read_enable,
  output logic [63:0]         read_addr,
  output logic                finish_read,
  input  logic                write_ready,
  output logic                write_enable,
  output logic [63:0]         write_addr,
  output logic [DATA_WID-1:0] write_data,
  output logic                finish_write,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DATA_WID-1:0] returnvalue,
  output logic                k_start,
  input  logic                k_done,
  input  logic [DATA_WID-1:0] k_return,
  input  logic [ADDR_WID-1:0] k_addr0,
  input  logic [ADDR_WID-1:0] k_addr1,
  input  logic                k_ce0,
  input  logic                k_ce1,
  input  logic                k_we0,
  input  logic                k_we1,
  input  logic [DATA_WID-1:0] k_d0,
  input  logic [DATA_WID-1:0] k_d1,
  output logic [DATA_WID-1:0] k_q0,
  output logic [DATA_WID-1:0] k_q1
);

  localparam int          DEPTH_N = 1 << ADDR_WID;
  localparam logic [63:0] DEPTH   = 64'(DEPTH_N);
  localparam logic [CNT_WID:0] CNT_ONE = (CNT_WID+1)'(1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_RUN, S_WRITE, S_DONE} state_t;
  state_t state, state_next;

  logic [DATA_WID-1:0] mem [DEPTH_N];
  logic [63:0]         rs_q, ws_q;
  logic [CNT_WID-1:0]  nr_q, nw_q, rd_cnt, wr_cnt;
  logic [31:0]         run_cnt;
  logic                args_bad, rd_fire, rd_last, wr_fire, wr_last, timeout_hit;

  // Handshake: a beat transfers on a rising edge where enable and ready are both
  // high; enable stays up (address/data stable) until the beat is taken.
  assign args_bad = (num_read == '0) || (64'(num_read) > DEPTH) || (64'(num_write) > DEPTH);
  assign rd_fire  = (state == S_READ) && read_ready;
  assign rd_last  = rd_fire && (({1'b0, rd_cnt} + CNT_ONE) == {1'b0, nr_q});
  assign wr_fire  = (state == S_WRITE) && write_ready;
  assign wr_last  = wr_fire && (({1'b0, wr_cnt} + CNT_ONE) == {1'b0, nw_q});
  // k_done in the same cycle as expiry wins, so it is excluded here.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (state == S_RUN) && !k_done && (run_cnt == TO_LAST);

  always_comb begin
    state_next   = state;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    write_data   = '0;
    busy         = (state != S_IDLE);
    done         = 1'b0;
    case (state)
      S_IDLE:  if (start) state_next = args_bad ? S_DONE : S_READ;
      S_READ: begin
        read_enable = 1'b1;
        if (rd_last) state_next = S_RUN;
      end
      S_RUN: begin
        if (k_done)           state_next = (nw_q != '0) ? S_WRITE : S_DONE;
        else if (timeout_hit) state_next = S_DONE;
      end
      S_WRITE: begin
        write_enable = 1'b1;
        write_data   = mem[wr_cnt[ADDR_WID-1:0]];
        if (wr_last) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      rs_q         <= '0;
      ws_q         <= '0;
      nr_q         <= '0;
      nw_q         <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      run_cnt      <= '0;
      read_addr    <= '0;
      write_addr   <= '0;
      finish_read  <= 1'b0;
      finish_write <= 1'b0;
      k_start      <= 1'b0;
      error        <= 1'b0;
      returnvalue  <= '0;
    end else begin
      state        <= state_next;
      finish_read  <= rd_fire && !rd_last;
      finish_write <= wr_fire && !wr_last;
      k_start      <= rd_last;
      case (state)
        S_IDLE: if (start) begin
          rs_q       <= read_stride;
          ws_q       <= write_stride;
          nr_q       <= num_read;
          nw_q       <= num_write;
          read_addr  <= read_base;
          write_addr <= write_base;
          rd_cnt     <= '0;
          wr_cnt     <= '0;
          error      <= args_bad;
        end
        S_READ: if (rd_fire) begin
          rd_cnt    <= rd_cnt + 1'b1;
          read_addr <= read_addr + rs_q;
          if (rd_last) run_cnt <= '0;
        end
        S_RUN: begin
          run_cnt <= run_cnt + 32'd1;
          if (k_done)           returnvalue <= k_return;
          else if (timeout_hit) error       <= 1'b1;
        end
        S_WRITE: if (wr_fire) begin
          wr_cnt     <= wr_cnt + 1'b1;
          write_addr <= write_addr + ws_q;
        end
        default: ;
      endcase
    end
  end

  // Buffer is deliberately not reset; port 1 is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (rd_fire) mem[rd_cnt[ADDR_WID-1:0]] <= read_data;
    if (state == S_RUN) begin
      if (k_ce0 && k_we0) mem[k_addr0] <= k_d0;
      if (k_ce1 && k_we1) mem[k_addr1] <= k_d1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q0 <= '0;
      k_q1 <= '0;
    end else if (state == S_RUN) begin
      if (k_ce0) k_q0 <= mem[k_addr0];
      if (k_ce1) k_q1 <= mem[k_addr1];
    end
  end

endmodule

// File: tb/tb_hls_kernel_shell.sv
// Bench for hls_kernel_shell: memory-side responders, a buffer model feeding an
// expected write-back queue, and directed kernel sequences.
module tb_hls_kernel_shell;
  localparam int DW = 32, AW = 5, CW = 16, TO = 50;

  logic          clk = 1'b0;
  logic          reset, start, read_ready, read_enable, finish_read;
  logic          write_ready, write_enable, finish_write, busy, done, error;
  logic          k_start, k_done, k_ce0, k_ce1, k_we0, k_we1;
  logic [63:0]   read_base, write_base, read_stride, write_stride, read_addr, write_addr;
  logic [CW-1:0] num_read, num_write;
  logic [DW-1:0] read_data, write_data, returnvalue, k_return, k_d0, k_d1, k_q0, k_q1;
  logic [AW-1:0] k_addr0, k_addr1;

  always #5 clk = ~clk;

  hls_kernel_shell #(.DATA_WID(DW), .ADDR_WID(AW), .CNT_WID(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .read_base(read_base), .write_base(write_base),
    .read_stride(read_stride), .write_stride(write_stride),
    .num_read(num_read), .num_write(num_write),
    .read_ready(read_ready), .read_data(read_data), .read_enable(read_enable),
    .read_addr(read_addr), .finish_read(finish_read),
    .write_ready(write_ready), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .finish_write(finish_write),
    .busy(busy), .done(done), .error(error), .returnvalue(returnvalue),
    .k_start(k_start), .k_done(k_done), .k_return(k_return),
    .k_addr0(k_addr0), .k_addr1(k_addr1), .k_ce0(k_ce0), .k_ce1(k_ce1),
    .k_we0(k_we0), .k_we1(k_we1), .k_d0(k_d0), .k_d1(k_d1), .k_q0(k_q0), .k_q1(k_q1)
  );

  int total = 0, bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [63:0]   exp_addr_q[$];
  logic [DW-1:0] rd_words[64];
  logic [DW-1:0] mdl[32];
  int cyc = 0, rd_beat = 0, wr_beat = 0, wr_limit = 1000, rd_mode = 0, wr_mode = 0;
  int fr_cnt = 0, fw_cnt = 0, done_cnt = 0, done_cyc = 0, kst_cyc = 0;
  logic done_err = 1'b0, rd_en_seen = 1'b0, wr_en_seen = 1'b0;
  logic [63:0] rd_base_e = '0, rd_stride_e = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Memory-side responders and event monitor, all at the falling edge.
  always @(negedge clk) begin
    if (read_enable) begin
      rd_en_seen = 1'b1;
      chk("rd_addr", read_addr, rd_base_e + 64'(rd_beat) * rd_stride_e);
    end
    if (write_enable) wr_en_seen = 1'b1;
    if (finish_read) fr_cnt++;
    if (finish_write) fw_cnt++;
    if (done) begin
      done_cnt++;
      done_err = error;
      done_cyc = cyc;
    end
    if (k_start) kst_cyc = cyc;
    case (rd_mode)
      0:       read_ready = 1'b1;
      1:       read_ready = ~read_ready;
      default: read_ready = 1'($urandom_range(0, 1));
    endcase
    if (reset) read_ready = 1'b0;
    read_data = rd_words[rd_beat & 63];
    if (read_enable && read_ready) rd_beat++;
    write_ready = (wr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (reset || wr_beat >= wr_limit) write_ready = 1'b0;
    if (write_enable && write_ready) begin
      if (exp_q.size() == 0) chk("wr_unexp", 64'(1), 64'(0));
      else begin
        chk("wr_data", 64'(write_data), 64'(exp_q.pop_front()));
        chk("wr_addr", write_addr, exp_addr_q.pop_front());
      end
      wr_beat++;
    end
  end

  task automatic chk_zero();
    chk("z_busy", 64'(busy), 64'(0));
    chk("z_done", 64'(done), 64'(0));
    chk("z_error", 64'(error), 64'(0));
    chk("z_ret", 64'(returnvalue), 64'(0));
    chk("z_rden", 64'(read_enable), 64'(0));
    chk("z_wren", 64'(write_enable), 64'(0));
    chk("z_kstart", 64'(k_start), 64'(0));
    chk("z_raddr", read_addr, 64'(0));
    chk("z_waddr", write_addr, 64'(0));
    chk("z_wdata", 64'(write_data), 64'(0));
    chk("z_frd", 64'(finish_read), 64'(0));
    chk("z_fwr", 64'(finish_write), 64'(0));
    chk("z_q0", 64'(k_q0), 64'(0));
    chk("z_q1", 64'(k_q1), 64'(0));
  endtask

  task automatic job_start(input logic [63:0] rb, input logic [63:0] rs,
                           input logic [63:0] wb, input logic [63:0] ws,
                           input int nr, input int nw);
    logic ok;
    ok = (nr >= 1) && (nr <= 32) && (nw <= 32);
    rd_beat = 0; wr_beat = 0; fr_cnt = 0; fw_cnt = 0;
    rd_en_seen = 1'b0; wr_en_seen = 1'b0;
    rd_base_e = rb; rd_stride_e = rs;
    if (ok) for (int i = 0; i < nr; i++) mdl[i] = rd_words[i];
    read_base = rb; read_stride = rs; write_base = wb; write_stride = ws;
    num_read = CW'(nr); num_write = CW'(nw); start = 1'b1;
    tick();
    // Scramble the arguments: the shell must have latched them already.
    start = 1'b0; read_base = ~rb; read_stride = 64'd9; write_base = ~wb;
    write_stride = 64'd7; num_read = CW'(1); num_write = CW'(1);
    if (ok) begin
      chk("st_rden", 64'(read_enable), 64'(1));
      chk("st_raddr", read_addr, rb);
    end
  endtask

  task automatic wait_kstart();
    for (int n = 0; n < 500 && !k_start; n++) tick();
    if (!k_start) chk("kst_timeout", 64'(0), 64'(1));
    else begin
      chk("kst_rden", 64'(read_enable), 64'(0));
      chk("kst_busy", 64'(busy), 64'(1));
    end
  endtask

  task automatic k_finish(input logic [DW-1:0] ret, input logic [63:0] wb,
                          input logic [63:0] ws, input int nw);
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back(mdl[i]);
      exp_addr_q.push_back(wb + 64'(i) * ws);
    end
    k_done = 1'b1; k_return = ret;
    tick();
    k_done = 1'b0; k_return = '0;
    chk("kd_ret", 64'(returnvalue), 64'(ret));
    if (nw > 0) begin
      chk("kd_wren", 64'(write_enable), 64'(1));
      chk("kd_waddr", write_addr, wb);
      chk("kd_wdata", 64'(write_data), 64'(mdl[0]));
    end else begin
      chk("kd_done", 64'(done), 64'(1));
      chk("kd_wren", 64'(write_enable), 64'(0));
    end
  endtask

  task automatic k_read0(input logic [AW-1:0] a, output logic [DW-1:0] q);
    k_ce0 = 1'b1; k_we0 = 1'b0; k_addr0 = a;
    tick();
    k_ce0 = 1'b0;
    q = k_q0;
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int n = 0; n < 3000 && done_cnt == d0; n++) tick();
    if (done_cnt == d0) chk("done_timeout", 64'(0), 64'(1));
    tick();
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [DW-1:0] q;
    int d_before;
    reset = 1'b1; start = 1'b0; read_ready = 1'b0; read_data = '0; write_ready = 1'b0;
    read_base = '0; write_base = '0; read_stride = '0; write_stride = '0;
    num_read = '0; num_write = '0; k_done = 1'b0; k_return = '0;
    k_addr0 = '0; k_addr1 = '0; k_ce0 = 1'b0; k_ce1 = 1'b0; k_we0 = 1'b0; k_we1 = 1'b0;
    k_d0 = '0; k_d1 = '0;
    for (int i = 0; i < 64; i++) rd_words[i] = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    repeat (3) tick();
    chk_zero();
    reset = 1'b0;
    tick();

    // Four words, kernel increments each through port 0 and returns 7.
    rd_mode = 0; wr_mode = 0;
    rd_words[0] = 32'h11; rd_words[1] = 32'h22; rd_words[2] = 32'h33; rd_words[3] = 32'h44;
    d_before = done_cnt;
    job_start(64'h1000, 64'd4, 64'h2000, 64'd4, 4, 4);
    wait_kstart();
    for (int i = 0; i < 4; i++) begin
      k_read0(AW'(i), q);
      k_ce0 = 1'b1; k_we0 = 1'b1; k_addr0 = AW'(i); k_d0 = q + 1;
      mdl[i] = q + 1;
      tick();
      k_ce0 = 1'b0; k_we0 = 1'b0;
    end
    k_finish(32'd7, 64'h2000, 64'd4, 4);
    wait_done();
    chk("t1_ret", 64'(returnvalue), 64'd7);
    chk("t1_done", 64'(done_cnt - d_before), 64'd1);
    chk("t1_err", 64'(done_err), 64'd0);
    chk("t1_left", 64'(exp_q.size()), 64'd0);
    chk("t1_fr", 64'(fr_cnt), 64'd3);
    chk("t1_fw", 64'(fw_cnt), 64'd3);

    // Full-depth read with toggling read_ready, random write_ready, identity kernel.
    rd_mode = 1; wr_mode = 1;
    for (int i = 0; i < 32; i++) rd_words[i] = $urandom;
    job_start(64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 64'h8000, 64'h10, 32, 32);
    wait_kstart();
    k_finish(32'hCAFE, 64'h8000, 64'h10, 32);
    wait_done();
    chk("t2_fr", 64'(fr_cnt), 64'd31);
    chk("t2_fw", 64'(fw_cnt), 64'd31);
    chk("t2_left", 64'(exp_q.size()), 64'd0);
    chk("t2_err", 64'(done_err), 64'd0);

    // Bad arguments finish one cycle after start with error and no reads.
    rd_mode = 0; wr_mode = 0;
    for (int t = 0; t < 3; t++) begin
      d_before = done_cnt;
      job_start(64'h40, 64'd4, 64'h80, 64'd4, (t == 0) ? 0 : (t == 1) ? 33 : 1, (t == 2) ? 33 : 2);
      chk("bad_done", 64'(done), 64'd1);
      chk("bad_err", 64'(error), 64'd1);
      tick();
      chk("bad_busy", 64'(busy), 64'd0);
      chk("bad_cnt", 64'(done_cnt - d_before), 64'd1);
      chk("bad_rden", 64'(rd_en_seen), 64'd0);
    end

    // Kernel never finishes: timeout with no write-back.
    job_start(64'h100, 64'd4, 64'h200, 64'd4, 2, 4);
    wait_kstart();
    wait_done();
    chk("to_cycles", 64'(done_cyc - kst_cyc), 64'(TO));
    chk("to_err", 64'(done_err), 64'd1);
    chk("to_wren", 64'(wr_en_seen), 64'd0);

    // Port collision, read-during-write, and num_write=0.
    for (int i = 0; i < 8; i++) rd_words[i] = 32'h100 + 32'(i);
    job_start(64'h300, 64'd4, 64'h400, 64'd4, 8, 0);
    wait_kstart();
    k_ce0 = 1'b1; k_we0 = 1'b1; k_addr0 = 5'd3; k_d0 = 32'hA;
    k_ce1 = 1'b1; k_we1 = 1'b1; k_addr1 = 5'd3; k_d1 = 32'hB;
    tick();
    mdl[3] = 32'hB;
    k_we0 = 1'b0; k_addr0 = 5'd5;
    k_addr1 = 5'd5; k_d1 = 32'h55;
    tick();
    chk("rdw_old", 64'(k_q0), 64'(mdl[5]));
    mdl[5] = 32'h55;
    k_we1 = 1'b0; k_addr1 = 5'd3;
    tick();
    k_ce0 = 1'b0; k_ce1 = 1'b0;
    chk("col_p1", 64'(k_q1), 64'(mdl[3]));
    chk("rdw_new", 64'(k_q0), 64'(mdl[5]));
    k_finish(32'h5A, 64'h400, 64'd4, 0);
    wait_done();
    chk("nw0_wren", 64'(wr_en_seen), 64'd0);
    chk("nw0_err", 64'(done_err), 64'd0);

    // Reset during write-back after two beats, then a job that reads the persisted buffer.
    for (int i = 0; i < 4; i++) rd_words[i] = 32'hD00 + 32'(i);
    wr_limit = 2;
    job_start(64'h500, 64'd4, 64'h600, 64'd8, 4, 4);
    wait_kstart();
    k_finish(32'h77, 64'h600, 64'd8, 4);
    for (int n = 0; n < 200 && wr_beat < 2; n++) tick();
    chk("rst_beats", 64'(wr_beat), 64'd2);
    d_before = done_cnt;
    reset = 1'b1;
    tick();
    chk_zero();
    reset = 1'b0;
    chk("rst_left", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    exp_addr_q.delete();
    wr_limit = 1000;
    repeat (3) tick();
    chk("rst_nodone", 64'(done_cnt - d_before), 64'd0);
    rd_words[0] = 32'hE0; rd_words[1] = 32'hE1;
    d_before = done_cnt;
    job_start(64'h700, 64'd4, 64'h900, 64'd4, 2, 4);
    wait_kstart();
    k_finish(32'h99, 64'h900, 64'd4, 4);
    wait_done();
    chk("re_done", 64'(done_cnt - d_before), 64'd1);
    chk("re_err", 64'(done_err), 64'd0);
    chk("re_left", 64'(exp_q.size()), 64'd0);
    chk("re_ret", 64'(returnvalue), 64'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hls_kernel_shell.md
# hls_kernel_shell

Parametrised host-side shell for a single HLS kernel with a dual-port buffer interface and an ap_start/ap_done handshake. A job is started with a `start` pulse. The shell then:
- burst-reads `num_read` words from memory into a local buffer;
- runs the kernel against that buffer and captures its return value;
- writes `num_write` words back, then pulses `done` and re-arms for the next job.

It sits between the memory-side read/write handshake ports and an externally instantiated kernel. It adds job restart, independent read/write counts and strides, argument checking, and a run timeout.

## Interface
- DATA_WID, 32, buffer word and kernel data width
- ADDR_WID, 5, buffer address width; DEPTH = 2^ADDR_WID words
- CNT_WID, 16, width of `num_read`/`num_write`
- TIMEOUT_CYC, 0, max cycles in RUN before abort; 0 disables
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  job request, sampled only in IDLE
- read_base, write_base  in  64  first read/write address
- read_stride, write_stride  in  64  address increment per beat
- num_read, num_write  in  CNT_WID  beats to read / write back
- read_ready  in  1  read_data valid; beat accepted when read_enable && read_ready
- read_data  in  DATA_WID  read beat data
- read_enable  out  1  read request active
- read_addr  out  64  current read address
- finish_read  out  1  one-cycle ack after each accepted non-final read beat
- write_ready  in  1  beat accepted when write_enable && write_ready
- write_enable  out  1  write request active
- write_addr  out  64  current write address
- write_data  out  DATA_WID  current write word
- finish_write  out  1  one-cycle ack after each accepted non-final write beat
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- error  out  1  valid with `done`: 1 = bad arguments or timeout
- returnvalue  out  DATA_WID  kernel `k_return` captured at `k_done`
- k_start  out  1  one-cycle kernel start pulse
- k_done  in  1  kernel completion
- k_return  in  DATA_WID  kernel return value
- k_addr0/k_addr1  in  ADDR_WID  kernel buffer addresses
- k_ce0/k_ce1, k_we0/k_we1  in  1  enables
- k_d0/k_d1  in  DATA_WID  write data
- k_q0/k_q1  out  DATA_WID  registered read data

## Operation
- States and transitions:
  - IDLE -> READ when `start` is high and arguments are valid.
  - IDLE -> DONE with error=1 when `start` is high and `num_read`==0, `num_read`>DEPTH or `num_write`>DEPTH.
  - READ -> RUN on the final accepted read beat.
  - RUN -> WRITE on `k_done` when `num_write`>0; RUN -> DONE when `num_write`==0.
  - RUN -> DONE with error=1 when the timeout expires.
  - WRITE -> DONE on the final accepted write beat.
  - DONE -> IDLE unconditionally.
- READ:
  - Each accepted beat writes buf[rd_cnt] = read_data, increments rd_cnt and adds `read_stride` to read_addr.
  - On the last beat, read_enable drops the next cycle.
- RUN:
  - `k_start` pulses on the first cycle.
  - Port 0 and port 1 are each serviced when ce=1: a write stores d; a read registers buf[addr] into q the next cycle.
  - Both ports writing the same address: port 1 wins.
  - Read and write to the same address in the same cycle: the read returns the old data.
  - On `k_done`, `returnvalue` = `k_return`.
- WRITE:
  - write_data = buf[wr_cnt]. Each accepted beat advances wr_cnt and write_addr (+`write_stride`) and presents the next word on the following cycle.
- Arithmetic:
  - Addresses wrap modulo 2^64.
  - Counts are compared as unsigned.
  - Buffer contents persist across jobs and across reset; reset does not clear them.
- Inputs `*_base`, `*_stride` and `num_*` are latched when `start` is accepted. Later changes during the job have no effect.

## Timing
- Reset: every output is 0. busy=0 and returnvalue=0. State goes to IDLE and all counters clear.
- Reset mid-job aborts immediately. There is no `done` pulse and no further beats.
- `start` is accepted at cycle T. At T+1, read_enable=1 and read_addr=read_base.
- With read_ready held high, the shell accepts 1 beat per cycle: N reads take N cycles.
- Final read beat at cycle R:
  - at R+1: read_enable=0, state=RUN, k_start=1;
  - at R+2: k_start=0.
- `k_done` at cycle K: write_enable=1, write_addr=write_base and write_data=buf[0] at K+1.
- Final accepted write at cycle W: write_enable=0 and done=1 at W+1; IDLE at W+2. `start` high at W+2 begins a new job.
- Timeout: if RUN lasts TIMEOUT_CYC cycles without `k_done`, done=1 and error=1 on the next cycle, with no write-back.
- A `k_done` arriving in the same cycle the timeout fires takes priority: normal completion.
- `start` outside IDLE is ignored.

## Test plan
- Read 4 words 0x11..0x44 (stride 4), then a kernel model adds 1 to each via port 0 and returns 7 -> writes 0x12..0x45 to write_base, write_base+4, …; returnvalue=7; done=1 once; error=0.
- read_ready toggled 1010… with num_read=DEPTH=32 -> all 32 words captured in order; finish_read pulses 31 times; read_addr advances only on accepted beats.
- num_read=0, then num_read=33 (DEPTH 32) -> done=1 and error=1 one cycle after start; read_enable is never asserted.
- TIMEOUT_CYC=50 with a kernel model that never asserts k_done -> done=1 and error=1 exactly 50 cycles after k_start; write_enable is never asserted.
- Both kernel ports write address 3 in the same cycle (d0=0xA, d1=0xB), then read it back -> buf[3]=0xB; num_write=0 -> done right after k_done with no writes.
- Reset asserted during WRITE at beat 2 -> all outputs 0 the next cycle and no done; then start a new job -> it completes normally.
